legv8_control_unit: RTL
=======================

Name: legv8_control_unit

Overview:
Multi-cycle control FSM that sits directly upstream of the LEGv8 datapath. It decodes the instruction register and status flags and drives the datapath's 36-bit control word plus the 64-bit immediate k each cycle. Memory accesses (fetch, LDUR, STUR) use a ready handshake with wait states.

Parameters:
WAIT_MAX, 15, memory wait cycles tolerated per access before entering HALT (0 = unlimited)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces IDLE
IR  in  32  instruction register output from datapath
status  in  4  latched flags {V,C,N,Z}; Z = bit 0
mem_ready  in  1  memory access completes this cycle
controlWord  out  36  {FS5,SA5,SB5,DA5,w_reg,C0,mem_cs2,B_Sel,mem_write_en,IR_load,status_load,size2,add_tri_sel,data_tri_sel2,PC_sel,PC_FS2}
k  out  64  immediate / offset for datapath
halted  out  1  FSM in HALT
state_dbg  out  3  current state encoding

Behaviour:
- States: IDLE, FETCH, EXEC, CBR, HALT. Outputs are a combinational function of state, IR, status and mem_ready; only the state and a 4-bit wait counter are registered.
- Reset (async): state = IDLE, wait counter = 0.
  - In IDLE: controlWord = 0 (no write, no mem_cs, PC_FS = HOLD) and k = 0.
  - IDLE -> FETCH on the next clock edge.
- FETCH:
  - Drive add_tri_sel = PC, data_tri_sel = MEM, mem_cs = RAM, size = DWORD, PC_FS = HOLD.
  - IR_load = mem_ready. Advance to EXEC only when mem_ready = 1; otherwise stay and count.
- EXEC, by opcode. The PC still holds the instruction address.
  - R-type ADD/SUB/AND/ORR/ADDS/SUBS: SA = Rn, SB = Rm, DA = Rd, B_Sel = reg, data_tri = ALU, w_reg = 1. status_load = 1 only for ADDS/SUBS.
  - I-type ADDI/SUBI/ANDI/ORRI: k = zero-extended IR[21:10], B_Sel = k.
  - LDUR: k = sign-extended IR[20:12]. Address comes from the ALU (Rn + k), data_tri = MEM, w_reg = mem_ready.
  - STUR: SB = Rt, data_tri = B, mem_write_en = mem_ready.
  - Both LDUR and STUR hold in EXEC until mem_ready.
  - B: k = sext(IR[25:0]) << 2, PC_sel = k, PC_FS = ADD.
  - B.cond: same PC update as B, but with k = sext(IR[23:5]) << 2. Taken per cond IR[3:0] (EQ, NE, LT, GE; other codes are never taken) evaluated on status. Not-taken uses PC_FS = INC.
  - BR: PC_sel = A, SA = Rn, PC_FS = LOAD.
  - CBZ/CBNZ: FS = PASS_B, SB = Rt, status_load = 1, PC_FS = HOLD, then go to CBR. CBZ/CBNZ clobber flags; this is documented behaviour.
  - All other completed instructions use PC_FS = INC and go back to FETCH.
- CBR: k = sext(IR[23:5]) << 2. Taken if Z == 1 (CBZ) or Z == 0 (CBNZ), giving PC_FS = ADD; otherwise INC. Then go to FETCH.
- Unknown opcode in EXEC: go to HALT, with no write and PC_FS = HOLD.
- WAIT_MAX: when the wait counter reaches WAIT_MAX without mem_ready, go to HALT. The counter clears on every state change.
- HALT: absorbing state with the IDLE control word and halted = 1; only reset exits it.
- Opcode priority: 11-bit matches first, then 10-bit, 8-bit, 6-bit.
- Reset asserted mid-access drops mem_cs and mem_write_en immediately, since they are asynchronous through state.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - FS codes (FS_ADD, FS_SUB, FS_AND, FS_OR, FS_PASS_B), matching the ALU_LEGv8 function table;
  - PC_FS codes: HOLD = 00, INC = 01, ADD = 10, LOAD = 11;
  - data_tri codes: ALU = 0, B = 1, PC4 = 2, MEM = 3;
  - addr codes: ALU = 0, PC = 1;
  - mem_cs RAM = 01; size DWORD = 11;
  - status bit indices.
- Sub-module legv8_imm_gen: combinational generation of k from IR and the selected format.

Test Plan:
- Reset release, mem_ready = 1, IR = 0x910017E1 (ADDI X1,XZR,#5): IDLE -> FETCH (IR_load = 1) -> EXEC with k = 5, DA = 1, SA = 31, w_reg = 1, PC_FS = INC.
- IR = 0x8B020023 (ADD X3,X1,X2): EXEC gives SA = 1, SB = 2, DA = 3, B_Sel = 0, status_load = 0, one-cycle EXEC.
- IR = 0xF8408022 (LDUR X2,[X1,#8]), mem_ready low for 3 cycles: EXEC is held 4 cycles; k = 8; w_reg = 1 only in the last cycle; PC_FS = INC only in that cycle.
- IR = 0xB4000065 (CBZ X5,#12): EXEC gives SB = 5, status_load = 1. In CBR with Z = 1: k = 12, PC_FS = ADD. With Z = 0: PC_FS = INC.
- IR = 0x17FFFFFE (B -8): k = 0xFFFFFFFFFFFFFFF8, PC_sel = 1, PC_FS = ADD.
- IR = 0x00000000: goes to HALT with halted = 1 and controlWord = 0. Separately, mem_ready held low 15 cycles in FETCH: goes to HALT. Async reset mid-FETCH: outputs go to IDLE values within the same cycle.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control unit: states, opcodes,
// control-word field codes and the control-word layout itself.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_CBR   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_D, IMM_B, IMM_CB} imm_fmt_t;

  typedef enum logic [4:0] {
    OP_BAD, OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR,
    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_LDUR, OP_STUR,
    OP_B, OP_BCOND, OP_BR, OP_CBZ, OP_CBNZ
  } op_t;

  localparam logic [10:0] OPC_ADD  = 11'h458;
  localparam logic [10:0] OPC_ADDS = 11'h558;
  localparam logic [10:0] OPC_SUB  = 11'h658;
  localparam logic [10:0] OPC_SUBS = 11'h758;
  localparam logic [10:0] OPC_AND  = 11'h450;
  localparam logic [10:0] OPC_ORR  = 11'h550;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [10:0] OPC_BR   = 11'h6B0;
  localparam logic [9:0]  OPC_ADDI = 10'h244;
  localparam logic [9:0]  OPC_SUBI = 10'h344;
  localparam logic [9:0]  OPC_ANDI = 10'h248;
  localparam logic [9:0]  OPC_ORRI = 10'h2C8;
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;
  localparam logic [7:0]  OPC_CBNZ = 8'hB5;
  localparam logic [7:0]  OPC_BCOND = 8'h54;
  localparam logic [5:0]  OPC_B    = 6'h05;

  // ALU function codes: {op_sel[2:0], invert_b, invert_a}
  localparam logic [4:0] FS_AND    = 5'b00000;
  localparam logic [4:0] FS_OR     = 5'b00100;
  localparam logic [4:0] FS_ADD    = 5'b01000;
  localparam logic [4:0] FS_SUB    = 5'b01010;
  localparam logic [4:0] FS_PASS_B = 5'b11000;

  localparam logic [1:0] PCFS_HOLD = 2'b00;
  localparam logic [1:0] PCFS_INC  = 2'b01;
  localparam logic [1:0] PCFS_ADD  = 2'b10;
  localparam logic [1:0] PCFS_LOAD = 2'b11;

  localparam logic [1:0] DT_ALU = 2'd0;
  localparam logic [1:0] DT_B   = 2'd1;
  localparam logic [1:0] DT_PC4 = 2'd2;
  localparam logic [1:0] DT_MEM = 2'd3;

  localparam logic ADDR_ALU = 1'b0;
  localparam logic ADDR_PC  = 1'b1;
  localparam logic BSEL_REG = 1'b0;
  localparam logic BSEL_K   = 1'b1;
  localparam logic PCSEL_A  = 1'b0;
  localparam logic PCSEL_K  = 1'b1;

  localparam logic [1:0] CS_RAM     = 2'b01;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_C = 2;
  localparam int STAT_V = 3;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;

  typedef struct packed {
    logic [4:0] fs;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       w_reg;
    logic       c0;
    logic [1:0] mem_cs;
    logic       b_sel;
    logic       mem_write_en;
    logic       ir_load;
    logic       status_load;
    logic [1:0] size;
    logic       add_tri_sel;
    logic [1:0] data_tri_sel;
    logic       pc_sel;
    logic [1:0] pc_fs;
  } ctrl_word_t;

  // Longest opcode match wins.
  function automatic op_t decode_op(input logic [10:0] opc);
    case (opc)
      OPC_ADD:  return OP_ADD;
      OPC_ADDS: return OP_ADDS;
      OPC_SUB:  return OP_SUB;
      OPC_SUBS: return OP_SUBS;
      OPC_AND:  return OP_AND;
      OPC_ORR:  return OP_ORR;
      OPC_LDUR: return OP_LDUR;
      OPC_STUR: return OP_STUR;
      OPC_BR:   return OP_BR;
      default:  ;
    endcase
    case (opc[10:1])
      OPC_ADDI: return OP_ADDI;
      OPC_SUBI: return OP_SUBI;
      OPC_ANDI: return OP_ANDI;
      OPC_ORRI: return OP_ORRI;
      default:  ;
    endcase
    case (opc[10:3])
      OPC_CBZ:   return OP_CBZ;
      OPC_CBNZ:  return OP_CBNZ;
      OPC_BCOND: return OP_BCOND;
      default:   ;
    endcase
    if (opc[10:5] == OPC_B) return OP_B;
    return OP_BAD;
  endfunction

  function automatic logic [4:0] alu_fs(input op_t op);
    case (op)
      OP_SUB, OP_SUBS, OP_SUBI: return FS_SUB;
      OP_AND, OP_ANDI:          return FS_AND;
      OP_ORR, OP_ORRI:          return FS_OR;
      default:                  return FS_ADD;
    endcase
  endfunction

  function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] flags);
    case (cond)
      COND_EQ: return flags[STAT_Z];
      COND_NE: return !flags[STAT_Z];
      COND_GE: return flags[STAT_N] == flags[STAT_V];
      COND_LT: return flags[STAT_N] != flags[STAT_V];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/legv8_imm_gen.sv
// Immediate generator: extracts and extends the instruction immediate
// selected by the decoder into the 64-bit k bus.
module legv8_imm_gen
  import legv8_ctrl_pkg::*;
(
  input  logic [25:0] field,
  input  imm_fmt_t    fmt,
  output logic [63:0] k
);

  always_comb begin
    k = '0;
    case (fmt)
      IMM_I:   k = {52'd0, field[21:10]};
      IMM_D:   k = {{55{field[20]}}, field[20:12]};
      IMM_B:   k = {{36{field[25]}}, field[25:0], 2'b00};
      IMM_CB:  k = {{43{field[23]}}, field[23:5], 2'b00};
      default: k = '0;
    endcase
  end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control FSM: decodes IR and flags into the datapath
// control word and immediate, with bounded memory wait states.
module legv8_control_unit
  import legv8_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [3:0]  status,
  input  logic        mem_ready,
  output logic [35:0] controlWord,
  output logic [63:0] k,
  output logic        halted,
  output logic [2:0]  state_dbg
);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       mem_wait;
  ctrl_word_t cw;
  imm_fmt_t   fmt;
  op_t        op;
  logic [4:0] rn, rm, rd;

  assign op = decode_op(IR[31:21]);
  assign rn = IR[9:5];
  assign rm = IR[20:16];
  assign rd = IR[4:0];

  legv8_imm_gen u_imm_gen (
    .field (IR[25:0]),
    .fmt   (fmt),
    .k     (k)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) wait_cnt <= '0;
      else if (mem_wait)      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    cw        = '0;
    fmt       = IMM_NONE;
    state_nxt = state;
    mem_wait  = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        cw.add_tri_sel  = ADDR_PC;
        cw.data_tri_sel = DT_MEM;
        cw.mem_cs       = CS_RAM;
        cw.size         = SIZE_DWORD;
        cw.ir_load      = mem_ready;
        if (mem_ready) state_nxt = ST_EXEC;
        else           mem_wait  = 1'b1;
      end
      ST_EXEC: begin
        cw.pc_fs  = PCFS_INC;
        state_nxt = ST_FETCH;
        case (op)
          OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR: begin
            cw.fs          = alu_fs(op);
            cw.c0          = (alu_fs(op) == FS_SUB);
            cw.sa          = rn;
            cw.sb          = rm;
            cw.da          = rd;
            cw.w_reg       = 1'b1;
            cw.status_load = (op == OP_ADDS) || (op == OP_SUBS);
          end
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: begin
            fmt      = IMM_I;
            cw.fs    = alu_fs(op);
            cw.c0    = (alu_fs(op) == FS_SUB);
            cw.sa    = rn;
            cw.da    = rd;
            cw.b_sel = BSEL_K;
            cw.w_reg = 1'b1;
          end
          OP_LDUR, OP_STUR: begin
            fmt            = IMM_D;
            cw.fs          = FS_ADD;
            cw.sa          = rn;
            cw.b_sel       = BSEL_K;
            cw.add_tri_sel = ADDR_ALU;
            cw.mem_cs      = CS_RAM;
            cw.size        = SIZE_DWORD;
            if (op == OP_LDUR) begin
              cw.da           = rd;
              cw.data_tri_sel = DT_MEM;
              cw.w_reg        = mem_ready;
            end else begin
              cw.sb           = rd;
              cw.data_tri_sel = DT_B;
              cw.mem_write_en = mem_ready;
            end
            // PC keeps the instruction address until the access completes
            if (!mem_ready) begin
              cw.pc_fs  = PCFS_HOLD;
              state_nxt = ST_EXEC;
              mem_wait  = 1'b1;
            end
          end
          OP_B: begin
            fmt       = IMM_B;
            cw.pc_sel = PCSEL_K;
            cw.pc_fs  = PCFS_ADD;
          end
          OP_BCOND: begin
            fmt       = IMM_CB;
            cw.pc_sel = PCSEL_K;
            cw.pc_fs  = cond_taken(IR[3:0], status) ? PCFS_ADD : PCFS_INC;
          end
          OP_BR: begin
            cw.sa     = rn;
            cw.pc_sel = PCSEL_A;
            cw.pc_fs  = PCFS_LOAD;
          end
          OP_CBZ, OP_CBNZ: begin
            // Flags are refreshed from Rt; the branch resolves next cycle in CBR
            cw.fs          = FS_PASS_B;
            cw.sb          = rd;
            cw.status_load = 1'b1;
            cw.pc_fs       = PCFS_HOLD;
            state_nxt      = ST_CBR;
          end
          default: begin
            cw.pc_fs  = PCFS_HOLD;
            state_nxt = ST_HALT;
          end
        endcase
      end
      ST_CBR: begin
        fmt       = IMM_CB;
        cw.pc_sel = PCSEL_K;
        cw.pc_fs  = ((op == OP_CBZ) == status[STAT_Z]) ? PCFS_ADD : PCFS_INC;
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_HALT;
    endcase
    if (mem_wait && WAIT_MAX != 0 && wait_cnt == 4'(WAIT_MAX - 1))
      state_nxt = ST_HALT;
  end

  assign controlWord = cw;
  assign halted      = (state == ST_HALT);
  assign state_dbg   = state;

endmodule
